enoc_adaptive_route_pipe: RTL and testbench
===========================================

ENOC_ADAPTIVE_ROUTE_PIPE -- requirements
Module: enoc_adaptive_route_pipe

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  X_NODES, 4, routers on X axis (>=2); Y_NODES, 4, routers on Y axis (>=2)
  X_LOC, 0, this router's X coordinate; Y_LOC, 0, this router's Y coordinate
  TORUS, 0, 0 = 2D mesh, 1 = 2D torus with wrap links
  ADAPTIVE, 0, 0 = dimension-ordered (X then Y), 1 = minimal congestion-adaptive
REQ-002 XW = max(1, ceil(log2(X_NODES))); YW = max(1, ceil(log2(Y_NODES))).
REQ-003 Ports (name direction width meaning), one per line:
  clk  in  1  single clock, all state on rising edge
  reset  in  1  asynchronous, active-high reset
  i_x_dest  in  XW  packet destination X
  i_y_dest  in  YW  packet destination Y
  i_val  in  1  upstream destination valid
  o_rdy  out  1  block can accept a destination this cycle
  i_cong  in  [0:3]  congestion flags for [n,e,s,w] outputs, 1 = congested
  o_output_req  out  [0:4]  registered one-hot request for [c,n,e,s,w]
  o_val  out  1  o_output_req/o_err valid
  i_rdy  in  1  downstream (switch allocator) accepts result
  o_err  out  1  captured destination out of range

Function
REQ-004 One-entry output register; capture when i_val && o_rdy; o_rdy = !o_val || i_rdy (combinational from i_rdy).
REQ-005 Latency: result on o_output_req/o_val exactly 1 cycle after capture; full throughput of 1/cycle when i_rdy held high.
REQ-006 o_val clears on a cycle with o_val && i_rdy and no new capture; simultaneous accept and capture replaces the entry, o_val stays 1.
REQ-007 While o_val && !i_rdy, o_output_req, o_err and o_val hold stable; i_cong changes after capture have no effect.
REQ-008 When o_val = 0, o_output_req = 5'b00000 and o_err = 0.
REQ-009 Route computed at capture from i_x_dest, i_y_dest and i_cong sampled that cycle.
REQ-010 i_x_dest >= X_NODES or i_y_dest >= Y_NODES: captured with o_output_req = 0, o_err = 1.
REQ-011 Destination equal to (X_LOC, Y_LOC): o_output_req = 5'b10000 (local).
REQ-012 Mesh X direction: east if dest > X_LOC, west if dest < X_LOC; Y: north if dest > Y_LOC, south if dest < Y_LOC.
REQ-013 Torus X: dx = (i_x_dest - X_LOC) mod X_NODES; dx = 0 none; 0 < dx <= X_NODES/2 (floor) east; else west. Tie at exactly half goes east. Y identical with north/south and Y_NODES.
REQ-014 Productive set P = {X direction if any} U {Y direction if any}.
REQ-015 ADAPTIVE = 0: X direction if present, else Y direction (dimension-ordered).
REQ-016 ADAPTIVE = 1, |P| = 1: that direction regardless of congestion.
REQ-017 ADAPTIVE = 1, |P| = 2, exactly one uncongested: choose the uncongested one.
REQ-018 ADAPTIVE = 1, |P| = 2, both congested or both uncongested: tie-break bit tb selects X when 0, Y when 1; tb toggles on each capture that used it, unchanged otherwise.
REQ-019 o_output_req always one-hot or zero; never more than one bit set.

Reset
REQ-020 reset asserted: immediately (asynchronous) o_val = 0, o_output_req = 0, o_err = 0, tb = 0, held while reset high.
REQ-021 Reset mid-operation discards any held entry; no captures while reset high; first capture possible on first rising edge after deassertion.

Verification
REQ-022 Mesh 4x4 at (1,1), ADAPTIVE=0, dest (3,2), i_rdy=1 -> one cycle later o_val=1, o_output_req=00100 (east).
REQ-023 Same, ADAPTIVE=1, i_cong=0100 (east congested) -> 01000 (north); i_cong=0000 twice in a row -> 00100 then 01000 (tb alternates).
REQ-024 Torus 4x4 at (0,0): dest (3,0) -> 00001 (west); dest (2,0) -> 00100 (east tie); dest (0,3) -> 00010 (south).
REQ-025 Backpressure: capture dest (0,0) at router (0,0) -> 10000; hold i_rdy=0 5 cycles with i_cong toggling -> outputs unchanged, o_rdy=0; raise i_rdy with new i_val -> new result next cycle, no gap.
REQ-026 X_NODES=3, dest x=3 -> o_err=1, o_output_req=0; reset asserted while o_val=1 -> o_val=0 without a clock edge, tb=0.

Source files
------------

// File: rtl/enoc_adaptive_route_pipe_if.sv
// Route-compute handshake bundle: upstream destination in, one-hot port request out.
interface enoc_adaptive_route_pipe_if #(
  parameter int XW = 2,
  parameter int YW = 2
);
  logic [XW-1:0] i_x_dest;
  logic [YW-1:0] i_y_dest;
  logic          i_val;
  logic          o_rdy;
  logic [0:3]    i_cong;
  logic [0:4]    o_output_req;
  logic          o_val;
  logic          i_rdy;
  logic          o_err;

  modport slave (
    input  i_x_dest, i_y_dest, i_val, i_cong, i_rdy,
    output o_rdy, o_output_req, o_val, o_err
  );

  modport master (
    output i_x_dest, i_y_dest, i_val, i_cong, i_rdy,
    input  o_rdy, o_output_req, o_val, o_err
  );
endinterface

// File: rtl/enoc_adaptive_route_pipe.sv
// Single-stage route computation for a mesh/torus router: picks one output port
// ([c,n,e,s,w]) per destination, dimension-ordered or minimal congestion-adaptive,
// and holds the result in a one-entry register until the allocator accepts it.
module enoc_adaptive_route_pipe #(
  parameter int X_NODES  = 4,
  parameter int Y_NODES  = 4,
  parameter int X_LOC    = 0,
  parameter int Y_LOC    = 0,
  parameter int TORUS    = 0,
  parameter int ADAPTIVE = 0
) (
  input logic clk,
  input logic reset,
  enoc_adaptive_route_pipe_if.slave rt
);

  logic       val_q;
  logic [0:4] req_q;
  logic       err_q;
  logic       tie_q;

  logic       capture;
  logic       dest_bad;
  logic       x_move, y_move;
  logic       x_pos, y_pos;
  logic       x_cong, y_cong;
  logic [0:4] x_req, y_req, route_req;
  logic       use_tie;
  int         x_fwd, y_fwd;

  assign rt.o_rdy        = !val_q || rt.i_rdy;
  assign rt.o_val        = val_q;
  assign rt.o_output_req = req_q;
  assign rt.o_err        = err_q;
  assign capture         = rt.i_val && rt.o_rdy;

  // Productive directions and final port choice for the destination on the bus.
  always_comb begin
    dest_bad  = (int'(rt.i_x_dest) >= X_NODES) || (int'(rt.i_y_dest) >= Y_NODES);
    x_move    = (int'(rt.i_x_dest) != X_LOC);
    y_move    = (int'(rt.i_y_dest) != Y_LOC);
    // Forward (east/north) hop count around the ring; only meaningful for a torus.
    x_fwd     = int'(rt.i_x_dest) - X_LOC;
    if (x_fwd < 0) x_fwd = x_fwd + X_NODES;
    y_fwd     = int'(rt.i_y_dest) - Y_LOC;
    if (y_fwd < 0) y_fwd = y_fwd + Y_NODES;
    if (TORUS != 0) begin
      // Half-way ties go east/north.
      x_pos = (x_fwd <= X_NODES / 2);
      y_pos = (y_fwd <= Y_NODES / 2);
    end else begin
      x_pos = (int'(rt.i_x_dest) > X_LOC);
      y_pos = (int'(rt.i_y_dest) > Y_LOC);
    end
    x_req     = '0;
    y_req     = '0;
    if (x_move) x_req = x_pos ? 5'b00100 : 5'b00001;
    if (y_move) y_req = y_pos ? 5'b01000 : 5'b00010;
    x_cong    = x_pos ? rt.i_cong[1] : rt.i_cong[3];
    y_cong    = y_pos ? rt.i_cong[0] : rt.i_cong[2];
    use_tie   = 1'b0;
    route_req = '0;
    if (dest_bad) begin
      route_req = '0;
    end else if (!x_move && !y_move) begin
      route_req = 5'b10000;
    end else if (!x_move) begin
      route_req = y_req;
    end else if (!y_move || (ADAPTIVE == 0)) begin
      route_req = x_req;
    end else if (x_cong != y_cong) begin
      route_req = x_cong ? y_req : x_req;
    end else begin
      use_tie   = 1'b1;
      route_req = tie_q ? y_req : x_req;
    end
  end

  // Output register: capture, drain, or hold under backpressure; tie bit flips when consulted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q <= 1'b0;
      req_q <= '0;
      err_q <= 1'b0;
      tie_q <= 1'b0;
    end else if (capture) begin
      val_q <= 1'b1;
      req_q <= route_req;
      err_q <= dest_bad;
      if (use_tie) tie_q <= !tie_q;
    end else if (rt.i_rdy) begin
      val_q <= 1'b0;
      req_q <= '0;
      err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_enoc_adaptive_route_pipe.sv
// Bench for enoc_adaptive_route_pipe: five differently configured routers share one
// stimulus stream; a hop-count reference model predicts every router's output.
module tb_enoc_adaptive_route_pipe;

  localparam int NDUT = 5;
  localparam int CFG_XN [NDUT] = '{4, 4, 4, 3, 4};
  localparam int CFG_YN [NDUT] = '{4, 4, 4, 4, 4};
  localparam int CFG_XL [NDUT] = '{1, 1, 0, 0, 2};
  localparam int CFG_YL [NDUT] = '{1, 1, 0, 0, 1};
  localparam int CFG_T  [NDUT] = '{0, 0, 1, 0, 1};
  localparam int CFG_A  [NDUT] = '{0, 1, 0, 0, 1};

  logic       clk;
  logic       reset;
  logic [1:0] x_dest, y_dest;
  logic       val, rdy;
  logic [0:3] cong;

  logic       o_val_a [NDUT];
  logic       o_rdy_a [NDUT];
  logic       o_err_a [NDUT];
  logic [0:4] o_req_a [NDUT];

  int checks = 0;
  int failures = 0;

  bit         m_val;
  logic [0:4] m_req [NDUT];
  bit         m_err [NDUT];
  bit         m_tie [NDUT];

  genvar g;
  generate
    for (g = 0; g < NDUT; g++) begin : gen_dut
      enoc_adaptive_route_pipe_if #(.XW(2), .YW(2)) bus ();
      assign bus.i_x_dest = x_dest;
      assign bus.i_y_dest = y_dest;
      assign bus.i_val    = val;
      assign bus.i_rdy    = rdy;
      assign bus.i_cong   = cong;
      assign o_val_a[g]   = bus.o_val;
      assign o_rdy_a[g]   = bus.o_rdy;
      assign o_err_a[g]   = bus.o_err;
      assign o_req_a[g]   = bus.o_output_req;
      enoc_adaptive_route_pipe #(
        .X_NODES(CFG_XN[g]), .Y_NODES(CFG_YN[g]),
        .X_LOC(CFG_XL[g]), .Y_LOC(CFG_YL[g]),
        .TORUS(CFG_T[g]), .ADAPTIVE(CFG_A[g])
      ) dut (
        .clk(clk),
        .reset(reset),
        .rt(bus.slave)
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Direction along one axis as a req bit index (0 = already there).
  function automatic int pick_dir(input int dst, input int loc, input int n, input int torus,
                                  input int pos_bit, input int neg_bit);
    int fwd;
    if (dst == loc) return 0;
    if (torus == 0) return (dst > loc) ? pos_bit : neg_bit;
    fwd = (dst - loc + n) % n;
    // Go the positive way when it is no longer than the way back round the ring.
    return (fwd <= n - fwd) ? pos_bit : neg_bit;
  endfunction

  function automatic void model_route(input int d, input int x, input int y, input logic [0:3] c,
                                      input bit tie, output logic [0:4] req, output bit err,
                                      output bit used);
    int xd, yd;
    req = '0; err = 1'b0; used = 1'b0;
    if (x >= CFG_XN[d] || y >= CFG_YN[d]) begin
      err = 1'b1;
      return;
    end
    xd = pick_dir(x, CFG_XL[d], CFG_XN[d], CFG_T[d], 2, 4);
    yd = pick_dir(y, CFG_YL[d], CFG_YN[d], CFG_T[d], 1, 3);
    if (xd == 0 && yd == 0)             req[0] = 1'b1;
    else if (yd == 0)                   req[xd] = 1'b1;
    else if (xd == 0)                   req[yd] = 1'b1;
    else if (CFG_A[d] == 0)             req[xd] = 1'b1;
    else if (c[xd-1] != c[yd-1])        req[c[xd-1] ? yd : xd] = 1'b1;
    else begin
      used = 1'b1;
      req[tie ? yd : xd] = 1'b1;
    end
  endfunction

  task automatic check_outputs();
    for (int d = 0; d < NDUT; d++) begin
      chk("o_val", d, {7'b0, o_val_a[d]}, {7'b0, m_val});
      chk("o_output_req", d, {3'b0, o_req_a[d]}, {3'b0, (m_val ? m_req[d] : 5'b00000)});
      chk("o_err", d, {7'b0, o_err_a[d]}, {7'b0, (m_val && m_err[d])});
      chk("onehot", d, {7'b0, ($countones(o_req_a[d]) <= 1)}, 8'd1);
    end
  endtask

  task automatic model_reset();
    m_val = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      m_req[d] = '0; m_err[d] = 1'b0; m_tie[d] = 1'b0;
    end
  endtask

  // One clock: drive at the falling edge, check o_rdy, advance the model, check outputs.
  task automatic step(input int x, input int y, input bit v, input bit r, input logic [0:3] c);
    bit cap;
    logic [0:4] rq;
    bit er, used;
    x_dest = 2'(x); y_dest = 2'(y); val = v; rdy = r; cong = c;
    #1;
    for (int d = 0; d < NDUT; d++)
      chk("o_rdy", d, {7'b0, o_rdy_a[d]}, {7'b0, (!m_val || r)});
    cap = v && (!m_val || r);
    @(posedge clk);
    if (cap) begin
      m_val = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
        model_route(d, x, y, c, m_tie[d], rq, er, used);
        m_req[d] = rq;
        m_err[d] = er;
        if (used) m_tie[d] = !m_tie[d];
      end
    end else if (r) begin
      model_reset_entry();
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic model_reset_entry();
    m_val = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      m_req[d] = '0; m_err[d] = 1'b0;
    end
  endtask

  typedef struct {
    int         dut;
    int         x;
    int         y;
    logic [0:3] cong;
    logic [0:4] req;
    bit         err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{0, 3, 2, 4'b0100, 5'b00100, 1'b0});
    vecs.push_back('{1, 3, 2, 4'b0100, 5'b01000, 1'b0});
    vecs.push_back('{1, 3, 2, 4'b0000, 5'b00100, 1'b0});
    vecs.push_back('{1, 3, 2, 4'b0000, 5'b01000, 1'b0});
    vecs.push_back('{2, 3, 0, 4'b0000, 5'b00001, 1'b0});
    vecs.push_back('{2, 2, 0, 4'b0000, 5'b00100, 1'b0});
    vecs.push_back('{2, 0, 3, 4'b0000, 5'b00010, 1'b0});
    vecs.push_back('{3, 3, 0, 4'b0000, 5'b00000, 1'b1});
    vecs.push_back('{3, 2, 3, 4'b0000, 5'b00100, 1'b0});
    vecs.push_back('{2, 0, 0, 4'b0000, 5'b10000, 1'b0});
    vecs.push_back('{0, 1, 1, 4'b0000, 5'b10000, 1'b0});
    vecs.push_back('{0, 0, 0, 4'b0000, 5'b00001, 1'b0});
    vecs.push_back('{0, 1, 3, 4'b0000, 5'b01000, 1'b0});

    reset = 1'b1; val = 1'b0; rdy = 1'b0; x_dest = '0; y_dest = '0; cong = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // Directed vectors, back to back with the allocator always ready.
    foreach (vecs[i]) begin
      step(vecs[i].x, vecs[i].y, 1'b1, 1'b1, vecs[i].cong);
      chk("vec_val", vecs[i].dut, {7'b0, o_val_a[vecs[i].dut]}, 8'd1);
      chk("vec_req", vecs[i].dut, {3'b0, o_req_a[vecs[i].dut]}, {3'b0, vecs[i].req});
      chk("vec_err", vecs[i].dut, {7'b0, o_err_a[vecs[i].dut]}, {7'b0, vecs[i].err});
    end

    // Backpressure on the torus router at (0,0): local result held while cong toggles.
    step(0, 0, 1'b1, 1'b1, 4'b0000);
    chk("bp_first", 2, {3'b0, o_req_a[2]}, 8'h10);
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 1'b1, 1'b0, (k % 2 == 0) ? 4'b1111 : 4'b0000);
      chk("bp_hold_req", 2, {3'b0, o_req_a[2]}, 8'h10);
      chk("bp_hold_rdy", 2, {7'b0, o_rdy_a[2]}, 8'd0);
    end
    step(3, 0, 1'b1, 1'b1, 4'b0000);
    chk("bp_release_val", 2, {7'b0, o_val_a[2]}, 8'd1);
    chk("bp_release_req", 2, {3'b0, o_req_a[2]}, 8'h01);

    // Leave the adaptive mesh router's tie bit set, then reset mid-entry.
    for (int k = 0; k < 3 && !m_tie[1]; k++) step(3, 2, 1'b1, 1'b1, 4'b0000);
    chk("tie_set", 1, {7'b0, m_tie[1]}, 8'd1);
    step(3, 0, 1'b1, 1'b0, 4'b0000);
    #2;
    reset = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("async_rst_val", d, {7'b0, o_val_a[d]}, 8'd0);
      chk("async_rst_req", d, {3'b0, o_req_a[d]}, 8'd0);
      chk("async_rst_err", d, {7'b0, o_err_a[d]}, 8'd0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
    step(3, 2, 1'b1, 1'b1, 4'b0000);
    chk("post_rst_tie", 1, {3'b0, o_req_a[1]}, 8'h04);

    // Randomized traffic with random backpressure and congestion.
    for (int n = 0; n < 2000; n++) begin
      step(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
